// File: rtl/found_result_collector_if.sv
// Bundle between the search-module array, the collector and the UART byte stream.
// Byte stream: a byte moves on a rising edge with tx_valid=1 and tx_ready=1; while
// tx_valid=1 and tx_ready=0 the source holds tx_data/tx_valid; tx_valid only falls after a transfer.
interface found_result_collector_if #(
  parameter int NUM_OF_TAPS    = 8,
  parameter int NUM_OF_MODULES = 30
);
  logic [NUM_OF_MODULES-1:0]               found;
  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf;
  logic [NUM_OF_MODULES-1:0]               res;
  logic [7:0]                              tx_data;
  logic                                    tx_valid;
  logic                                    tx_ready;
  logic                                    busy;
  logic [2:0]                              state_dbg;

  modport master (
    input  found, co_buf, tx_ready,
    output res, tx_data, tx_valid, busy, state_dbg
  );

  modport slave (
    output found, co_buf, tx_ready,
    input  res, tx_data, tx_valid, busy, state_dbg
  );
endinterface

// File: rtl/found_result_collector.sv
// Round-robin collector: frames each search hit as SYNC, idx, taps (MSB first) and acks it via res.
// Optional trailing XOR checksum byte when FOUND_COLLECTOR_CHECKSUM_EN is defined.
module found_result_collector #(
  parameter int         NUM_OF_TAPS    = 8,
  parameter int         NUM_OF_MODULES = 30,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input logic                      clk,
  input logic                      rst,
  found_result_collector_if.master bus
);
  localparam int TAP_W = NUM_OF_TAPS * 8;
  localparam int IDX_W = (NUM_OF_MODULES > 1) ? $clog2(NUM_OF_MODULES) : 1;
  localparam int N_W   = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_MODULES - 1);
  localparam logic [N_W-1:0]   LAST_N   = N_W'(NUM_OF_TAPS - 1);

  localparam logic [2:0] ST_SCAN = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_IDX  = 3'd2;
  localparam logic [2:0] ST_TAP  = 3'd3;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
  localparam logic [2:0] ST_CHK  = 3'd4;
`endif
  localparam logic [2:0] ST_ACK  = 3'd5;
  localparam logic [2:0] ST_WCLR = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [TAP_W-1:0] cap_q, cap_d;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  logic                      xfer;
  logic [7:0]                tx_data_c;
  logic                      tx_valid_c;
  logic [NUM_OF_MODULES-1:0] res_c;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign xfer = tx_valid_c & bus.tx_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    n_d     = n_q;
    cap_d   = cap_q;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (bus.found[ptr_q]) begin
          cap_d   = bus.co_buf[ptr_q*TAP_W +: TAP_W];
          idx_d   = ptr_q;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
          chk_d   = 8'(ptr_q);
`endif
          state_d = ST_HDR;
        end else begin
          ptr_d = wrap_inc(ptr_q);
        end
      end
      ST_HDR: if (xfer) state_d = ST_IDX;
      ST_IDX: begin
        if (xfer) begin
          state_d = ST_TAP;
          n_d     = '0;
        end
      end
      ST_TAP: begin
        // The capture register shifts left so the outgoing byte is always its top byte.
        if (xfer) begin
          cap_d = cap_q << 8;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
          chk_d = chk_q ^ cap_q[TAP_W-1 -: 8];
`endif
          if (n_q == LAST_N) begin
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_ACK;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
      ST_CHK: if (xfer) state_d = ST_ACK;
`endif
      ST_ACK: state_d = ST_WCLR;
      ST_WCLR: begin
        // Resume scanning after the reported module so pending neighbours get served first.
        if (!bus.found[idx_q]) begin
          ptr_d   = wrap_inc(idx_q);
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    res_c      = '0;
    case (state_q)
      ST_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = SYNC_BYTE;
      end
      ST_IDX: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'(idx_q);
      end
      ST_TAP: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cap_q[TAP_W-1 -: 8];
      end
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
      ST_CHK: begin
        tx_valid_c = 1'b1;
        tx_data_c  = chk_q;
      end
`endif
      ST_ACK: res_c[idx_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SCAN;
      ptr_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      cap_q   <= '0;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cap_q   <= cap_d;
`ifdef FOUND_COLLECTOR_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.res       = res_c;
  assign bus.busy      = (state_q != ST_SCAN);
  assign bus.state_dbg = state_q;
endmodule
